// File: rtl/nibble_serial_adder_pkg.sv
// nibble_serial_adder_pkg: shared slice width and controller state encoding
package nibble_serial_adder_pkg;
    localparam int SLICE = 4;
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;
endpackage

// File: rtl/bitfouradder.sv
// bitfouradder: 4-bit ripple-carry adder slice
module bitfouradder
    import nibble_serial_adder_pkg::*;
(
    input  logic [SLICE-1:0] a,
    input  logic [SLICE-1:0] b,
    input  logic             cin,
    output logic [SLICE-1:0] sum,
    output logic             cout
);
    logic [SLICE:0] c;
    assign c[0] = cin;
    for (genvar i = 0; i < SLICE; i++) begin : g_fa
        assign sum[i]  = a[i] ^ b[i] ^ c[i];
        assign c[i+1]  = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
    assign cout = c[SLICE];
endmodule

// File: rtl/nibble_serial_adder.sv
// nibble_serial_adder: W-bit adder computed one 4-bit slice per clock, LSB first
module nibble_serial_adder
    import nibble_serial_adder_pkg::*;
#(
    parameter  int NIBBLES = 4,
    localparam int W       = SLICE * NIBBLES
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [W-1:0] Ain,
    input  logic [W-1:0] Bin,
    input  logic         Cin,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] S,
    output logic         Cout,
    output logic         overflow
);
    localparam int CW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    state_t           state, state_n;
    logic [W-1:0]     a_q, b_q;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic [SLICE-1:0] sum;
    logic             co;
    logic             last;
    bitfouradder u_slice (
        .a    (a_q[cnt*SLICE +: SLICE]),
        .b    (b_q[cnt*SLICE +: SLICE]),
        .cin  (carry),
        .sum  (sum),
        .cout (co)
    );
    assign last = (cnt == CW'(NIBBLES - 1));
    always_comb begin
        state_n = (state == IDLE) ? (start ? RUN : IDLE) :
                  (state == RUN)  ? (last ? DONE : RUN) : IDLE;
        busy    = (state == RUN);
        done    = (state == DONE);
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            carry    <= 1'b0;
            cnt      <= '0;
            S        <= '0;
            Cout     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            state <= state_n;
            if (state == IDLE && start) begin
                a_q   <= Ain;
                b_q   <= Bin;
                carry <= Cin;
                cnt   <= '0;
            end
            if (state == RUN) begin
                S[cnt*SLICE +: SLICE] <= sum;
                carry                 <= co;
                cnt                   <= cnt + 1'b1;
                // the top slice's sum bit is the result sign used for overflow
                if (last) begin
                    Cout     <= co;
                    overflow <= (a_q[W-1] == b_q[W-1]) && (sum[SLICE-1] != a_q[W-1]);
                end
            end
        end
    end
endmodule

// File: tb/tb_nibble_serial_adder.sv
// tb_nibble_serial_adder: directed vectors checked against a cycle-count result model
module tb_nibble_serial_adder;
    localparam int N = 4;
    localparam int W = 4 * N;
    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] Ain = '0, Bin = '0;
    logic         Cin = 1'b0;
    logic         busy, done, Cout, overflow;
    logic [W-1:0] S;
    int           tests = 0, fails = 0;
    int           phase = -1;
    logic [W:0]   pend = '0;
    logic         pend_ov = 1'b0;
    logic [W-1:0] exp_s = '0;
    logic         exp_co = 1'b0, exp_ov = 1'b0;

    nibble_serial_adder #(.NIBBLES(N)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .Ain(Ain), .Bin(Bin), .Cin(Cin),
        .busy(busy), .done(done), .S(S), .Cout(Cout), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: phase counts edges since acceptance; result published when phase reaches N
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase  = -1;
            exp_s  = '0;
            exp_co = 1'b0;
            exp_ov = 1'b0;
        end else if (phase == -1) begin
            if (start) begin
                pend    = {1'b0, Ain} + {1'b0, Bin} + (W+1)'(Cin);
                pend_ov = (Ain[W-1] == Bin[W-1]) && (pend[W-1] != Ain[W-1]);
                phase   = 0;
            end
        end else if (phase == N) begin
            phase = -1;
        end else begin
            phase++;
            if (phase == N) begin
                exp_s  = pend[W-1:0];
                exp_co = pend[W];
                exp_ov = pend_ov;
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            check("busy", 32'(busy), 32'(phase >= 0 && phase < N));
            check("done", 32'(done), 32'(phase == N));
            if (phase == -1 || phase == N) begin
                check("S", 32'(S), 32'(exp_s));
                check("Cout", 32'(Cout), 32'(exp_co));
                check("overflow", 32'(overflow), 32'(exp_ov));
            end
        end
    end

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                          input logic [W-1:0] es, input logic eco, input logic eov);
        int n;
        @(negedge clk);
        Ain = a; Bin = b; Cin = c; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (!done && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("latency", 32'(n), 32'(N));
        check("lit_S", 32'(S), 32'(es));
        check("lit_Cout", 32'(Cout), 32'(eco));
        check("lit_overflow", 32'(overflow), 32'(eov));
    endtask

    initial begin
        int ndone, last_t, cyc;
        #3;
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_S", 32'(S), 0);
        check("rst_Cout", 32'(Cout), 0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op(16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0);
        run_op(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
        run_op(16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0, 1'b0);
        run_op(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
        run_op(16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1);
        // start and operand changes while busy are ignored
        @(negedge clk);
        Ain = 16'h00FF; Bin = 16'h0001; Cin = 1'b0; start = 1'b1;
        @(negedge clk);
        Ain = 16'hAAAA; Bin = 16'h5555;
        ndone = 0;
        for (int i = 0; i < 10; i++) begin
            if (i == 2) start = 1'b0;
            if (i == 3) begin Ain = 16'h1111; Bin = 16'h2222; Cin = 1'b1; end
            if (done) begin
                ndone++;
                check("ignore_S", 32'(S), 32'h0100);
            end
            @(negedge clk);
        end
        check("ignore_done_count", 32'(ndone), 1);
        // reset at the second RUN edge aborts with no done
        Ain = 16'h1234; Bin = 16'h1111; Cin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_busy", 32'(busy), 0);
        check("abort_S", 32'(S), 0);
        check("abort_done", 32'(done), 0);
        ndone = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (done) ndone++;
        end
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (done) ndone++;
        end
        check("abort_no_done", 32'(ndone), 0);
        run_op(16'h0F0F, 16'hF0F0, 1'b0, 16'hFFFF, 1'b0, 1'b0);
        // start held high: one operation every 6 cycles
        @(negedge clk);
        Ain = 16'h0102; Bin = 16'h0304; Cin = 1'b1; start = 1'b1;
        ndone = 0; last_t = -1; cyc = 0;
        for (int i = 0; i < 18; i++) begin
            @(negedge clk);
            cyc++;
            if (done) begin
                if (last_t >= 0) check("b2b_period", 32'(cyc - last_t), 6);
                last_t = cyc;
                ndone++;
                check("b2b_S", 32'(S), 32'h0407);
            end
        end
        start = 1'b0;
        check("b2b_done_count", 32'(ndone), 3);
        repeat (8) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
